// File: rtl/vdp_interpo_pkg.sv
// Shared constants and helpers for the VDP horizontal interpolation sequencer.
// Widths of the step/phase and line-length fields plus the sequencer state encoding.
package vdp_interpo_pkg;

    localparam int unsigned StepW = 4;
    localparam int unsigned FracW = 3;
    localparam int unsigned LenW  = 10;

    localparam logic [StepW-1:0] StepMax = 4'd8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPrimeA = 3'd1,
        StPrimeB = 3'd2,
        StRun    = 3'd3,
        StDrain  = 3'd4
    } state_e;

    // Zero means a full input pixel per output; anything past 8 is clamped so
    // phase + step always fits the 4-bit accumulator.
    function automatic logic [StepW-1:0] norm_step(input logic [StepW-1:0] s);
        return ((s == '0) || (s > StepMax)) ? StepMax : s;
    endfunction

    function automatic logic [LenW-1:0] norm_len(input logic [LenW-1:0] l);
        return (l == '0) ? LenW'(1) : l;
    endfunction

endpackage

// File: rtl/interpo_hstep.sv
// Horizontal interpolation sequencer: holds an A/B sample pair, steps a fractional
// phase, and emits A + (B-A)*phase/8 via an external multiplier, one output per slot.
module interpo_hstep
    import vdp_interpo_pkg::*;
#(
    parameter int unsigned MSBI = 7
) (
    input  logic             CLK21M,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [StepW-1:0] STEP,
    input  logic [LenW-1:0]  LINE_LEN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [MSBI:0]    IN_PIX,
    output logic [MSBI+1:0]  DIFF,
    output logic [FracW-1:0] WEIGHT,
    input  logic [MSBI+4:0]  OFF,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [MSBI:0]    OUT_PIX,
    output logic             BUSY
);

    state_e           state_q, state_d;
    logic [FracW-1:0] phase_q, phase_d;
    logic [LenW-1:0]  cnt_q, cnt_d;
    logic [StepW-1:0] step_q, step_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [MSBI:0]    a_q, a_d;
    logic [MSBI:0]    b_q, b_d;
    logic             out_valid_q, out_valid_d;
    logic [MSBI:0]    out_pix_q, out_pix_d;

    logic [StepW-1:0]       nxt;
    logic                   carry;
    logic [LenW-1:0]        cnt_inc;
    logic                   last;
    logic                   need_in;
    logic                   slot;
    logic                   fire;
    logic                   in_acc;
    logic signed [MSBI+4:0] off_sh;
    logic [MSBI+4:0]        sum_w;

    assign nxt     = {1'b0, phase_q} + step_q;
    assign carry   = nxt[StepW-1];
    assign cnt_inc = cnt_q + 1'b1;
    assign last    = (cnt_inc == len_q);
    // The final output of a line neither waits for nor consumes a new sample.
    assign need_in = carry & ~last;
    assign slot    = ~out_valid_q | OUT_READY;

    assign fire = (state_q == StRun) & slot & (~need_in | IN_VALID) & ~START;

    always_comb begin
        IN_READY = 1'b0;
        unique case (state_q)
            StPrimeA, StPrimeB: IN_READY = ~START;
            StRun:              IN_READY = slot & need_in & ~START;
            default:            IN_READY = 1'b0;
        endcase
    end

    assign in_acc = IN_READY & IN_VALID;

    // Arithmetic shift floors the signed offset; the sum stays between A and B.
    assign off_sh = $signed(OFF) >>> FracW;
    assign sum_w  = {4'b0000, a_q} + off_sh;

    assign DIFF      = {1'b0, b_q} - {1'b0, a_q};
    assign WEIGHT    = phase_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_PIX   = out_pix_q;
    assign BUSY      = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        len_d       = len_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;

        if (START) begin
            step_d      = norm_step(STEP);
            len_d       = norm_len(LINE_LEN);
            phase_d     = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            a_d         = '0;
            b_d         = '0;
            state_d     = StPrimeA;
        end else begin
            if (out_valid_q && OUT_READY) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StPrimeA: begin
                    if (in_acc) begin
                        a_d     = IN_PIX;
                        state_d = StPrimeB;
                    end
                end
                StPrimeB: begin
                    if (in_acc) begin
                        b_d     = IN_PIX;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (fire) begin
                        out_pix_d   = sum_w[MSBI:0];
                        out_valid_d = 1'b1;
                        phase_d     = nxt[FracW-1:0];
                        cnt_d       = cnt_inc;
                        if (need_in) begin
                            a_d = b_q;
                            b_d = IN_PIX;
                        end
                        if (last) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (slot) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            cnt_q       <= '0;
            step_q      <= StepMax;
            len_q       <= LenW'(1);
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            len_q       <= len_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
        end
    end

endmodule
